// File: rtl/fma16_issue_scheduler.sv
// Shares one fixed-latency pipelined fma16 datapath between two requesters:
// round-robin grant, operand issue, owner-tag tracking and a credited response FIFO.
module fma16_issue_scheduler #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_x0,
  input  logic [15:0] req_y0,
  input  logic [15:0] req_z0,
  input  logic [15:0] req_x1,
  input  logic [15:0] req_y1,
  input  logic [15:0] req_z1,
  input  logic [3:0]  req_ctrl0,
  input  logic [3:0]  req_ctrl1,
  output logic        fma_issue,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic [3:0]  fma_ctrl,
  input  logic [15:0] fma_result,
  input  logic [4:0]  fma_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [4:0]  resp_flags,
  output logic        resp_id,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = 22;  // {id, flags[4:0], data[15:0]}

  // ---------------- credit and arbitration ----------------
  logic [CW-1:0] credit_reg;
  logic [CW-1:0] credit_next;
  logic          credit_ok;
  logic          rr_reg;
  logic [1:0]    grant;
  logic          grant_id;
  logic          hs;
  logic          pop;

  assign credit_ok = (credit_reg < CW'(DEPTH));

  always_comb begin
    grant = 2'b00;
    if (credit_ok) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_reg ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign grant_id  = grant[1];
  assign hs        = |(req_valid & grant);
  assign pop       = resp_valid & resp_ready;

  always_comb begin
    credit_next = credit_reg;
    case ({hs, pop})
      2'b10:   credit_next = credit_reg + CW'(1);
      2'b01:   credit_next = credit_reg - CW'(1);
      default: credit_next = credit_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      credit_reg <= '0;
      rr_reg     <= 1'b0;
    end else begin
      credit_reg <= credit_next;
      if (hs) rr_reg <= ~grant_id;
    end
  end

  assign busy = (credit_reg != '0);

  // ---------------- operand issue ----------------
  logic        issue_reg;
  logic        owner_reg;
  logic [15:0] x_reg;
  logic [15:0] y_reg;
  logic [15:0] z_reg;
  logic [3:0]  ctrl_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      issue_reg <= 1'b0;
      owner_reg <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      ctrl_reg  <= '0;
    end else begin
      issue_reg <= hs;
      if (hs) begin
        owner_reg <= grant_id;
        x_reg     <= grant_id ? req_x1 : req_x0;
        y_reg     <= grant_id ? req_y1 : req_y0;
        z_reg     <= grant_id ? req_z1 : req_z0;
        ctrl_reg  <= grant_id ? req_ctrl1 : req_ctrl0;
      end
    end
  end

  assign fma_issue = issue_reg;
  assign fma_x     = x_reg;
  assign fma_y     = y_reg;
  assign fma_z     = z_reg;
  assign fma_ctrl  = ctrl_reg;

  // ---------------- owner tag pipeline, aligned with the datapath ----------------
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_id;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_tag
      logic valid_in;
      logic id_in;
      logic valid_reg;
      logic id_reg;

      if (gi == 0) begin : g_head
        assign valid_in = issue_reg;
        assign id_in    = owner_reg;
      end else begin : g_body
        assign valid_in = tag_valid[gi-1];
        assign id_in    = tag_id[gi-1];
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          valid_reg <= 1'b0;
          id_reg    <= 1'b0;
        end else begin
          valid_reg <= valid_in;
          id_reg    <= id_in;
        end
      end

      assign tag_valid[gi] = valid_reg;
      assign tag_id[gi]    = id_reg;
    end
  endgenerate

  // ---------------- response FIFO ----------------
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          full;
  logic [EW-1:0] head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign push = tag_valid[LATENCY-1];
  assign full = (count_reg == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {tag_id[LATENCY-1], fma_flags, fma_result};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Credit makes this unreachable; it guards against a broken credit path.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(push && full)) else $error("push into full response fifo");
    end
  end

  // Head is forced to zero when empty so outputs read 0 straight out of reset.
  assign head       = mem[rd_ptr_reg];
  assign resp_valid = (count_reg != '0);
  assign resp_data  = resp_valid ? head[15:0]  : 16'h0000;
  assign resp_flags = resp_valid ? head[20:16] : 5'b00000;
  assign resp_id    = resp_valid ? head[21]    : 1'b0;

endmodule

// File: tb/tb_fma16_issue_scheduler.sv
// Directed bench for fma16_issue_scheduler with a behavioural datapath pipeline and
// an in-order response scoreboard.
module tb_fma16_issue_scheduler;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_x0, req_y0, req_z0, req_x1, req_y1, req_z1;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic        fma_issue;
  logic [15:0] fma_x, fma_y, fma_z;
  logic [3:0]  fma_ctrl;
  logic [15:0] fma_result;
  logic [4:0]  fma_flags;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [4:0]  resp_flags;
  logic        resp_id;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fma16_issue_scheduler #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_z0(req_z0),
    .req_x1(req_x1), .req_y1(req_y1), .req_z1(req_z1),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .fma_issue(fma_issue), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z), .fma_ctrl(fma_ctrl),
    .fma_result(fma_result), .fma_flags(fma_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_flags(resp_flags), .resp_id(resp_id),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Hand-computed fp16 results for the operand patterns this bench uses.
  function automatic logic [20:0] dp_model(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z);
    if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00) return {5'b00000, 16'h4200};
    if (x == 16'h7C00 && y == 16'h0000) return {5'b10000, 16'h7E00};
    if (y == 16'h3C00 && z == 16'h0000) return {5'b00000, x};
    return {5'b10000, 16'h7E00};
  endfunction

  // Datapath: not reset, so ops in flight across a reset still emerge on the bus.
  bit          dp_v [LATENCY];
  logic [20:0] dp_q [LATENCY];
  always @(posedge clk) begin
    dp_v[0] <= fma_issue;
    dp_q[0] <= dp_model(fma_x, fma_y, fma_z);
    for (int i = 1; i < LATENCY; i++) begin
      dp_v[i] <= dp_v[i-1];
      dp_q[i] <= dp_q[i-1];
    end
  end
  assign fma_result = dp_v[LATENCY-1] ? dp_q[LATENCY-1][15:0]  : 16'hFFFF;
  assign fma_flags  = dp_v[LATENCY-1] ? dp_q[LATENCY-1][20:16] : 5'b11111;

  // Scoreboard entries {id, flags, data}; its size equals the credit count at each negedge.
  logic [21:0] sb [$];
  always @(negedge clk) begin : mon
    logic [1:0]  hs;
    logic [21:0] e;
    if (!reset_n) begin
      sb.delete();
    end else begin
      check("busy", busy, sb.size() != 0);
      check("ready_onehot", req_ready == 2'b11, 0);
      check("no_grant_when_full", (sb.size() >= DEPTH) && (req_ready != 2'b00), 0);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("stale_resp", resp_valid, 0);
        end else begin
          check("resp_data", resp_data, sb[0][15:0]);
          check("resp_flags", resp_flags, sb[0][20:16]);
          check("resp_id", resp_id, sb[0][21]);
          if (resp_ready) begin
            e = sb.pop_front();
            $display("resp id=%0d data=%h flags=%b", resp_id, resp_data, resp_flags);
          end
        end
      end
      hs = req_valid & req_ready;
      if (hs[0]) sb.push_back({1'b0, dp_model(req_x0, req_y0, req_z0)});
      if (hs[1]) sb.push_back({1'b1, dp_model(req_x1, req_y1, req_z1)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || resp_valid) && n < 60) begin
      cyc();
      n++;
    end
    check(tag, sb.size(), 0);
  endtask

  // Unloaded single op from the drive point: checks issue timing and the response at t+5.
  task automatic single_op(input string tag, input logic id, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] z, input logic [3:0] ctrl,
                           input logic [15:0] exp_d, input logic [4:0] exp_f);
    if (id) begin
      req_x1 = x; req_y1 = y; req_z1 = z; req_ctrl1 = ctrl; req_valid = 2'b10;
    end else begin
      req_x0 = x; req_y0 = y; req_z0 = z; req_ctrl0 = ctrl; req_valid = 2'b01;
    end
    mid(); check({tag, "_ready"}, req_ready, id ? 2'b10 : 2'b01);
    cyc(); req_valid = 2'b00;
    mid();
    check({tag, "_issue"}, fma_issue, 1);
    check({tag, "_fx"}, fma_x, x);
    check({tag, "_fy"}, fma_y, y);
    check({tag, "_fz"}, fma_z, z);
    check({tag, "_fctrl"}, fma_ctrl, ctrl);
    cyc(); mid(); check({tag, "_issue_once"}, fma_issue, 0);
    cyc(); mid();
    cyc(); mid(); check({tag, "_early"}, resp_valid, 0);
    cyc(); mid();
    check({tag, "_rvalid"}, resp_valid, 1);
    check({tag, "_rdata"}, resp_data, exp_d);
    check({tag, "_rflags"}, resp_flags, exp_f);
    check({tag, "_rid"}, resp_id, id);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic       g [6];
    logic [1:0] h;
    int         n;
    int         cnt;
    int         overlap;
    int         seen;

    reset_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
    req_x0 = '0; req_y0 = '0; req_z0 = '0; req_ctrl0 = '0;
    req_x1 = '0; req_y1 = '0; req_z1 = '0; req_ctrl1 = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    mid();
    check("rst_issue", fma_issue, 0);
    check("rst_fx", fma_x, 0);
    check("rst_rvalid", resp_valid, 0);
    check("rst_rdata", resp_data, 0);
    check("rst_busy", busy, 0);
    cyc(); reset_n = 1'b1;

    // 1: single op on requester 0, 1*2+1 = 3
    single_op("t1", 1'b0, 16'h3C00, 16'h4000, 16'h3C00, 4'b0000, 16'h4200, 5'b00000);
    wait_drain("t1_drain");

    // 6: inf*0 on requester 1 gives NaN with NV forwarded
    single_op("t6", 1'b1, 16'h7C00, 16'h0000, 16'h3C00, 4'b1010, 16'h7E00, 5'b10000);
    wait_drain("t6_drain");

    // 2: both requesters valid; last grant went to 1, so grants alternate starting with 0
    req_x0 = 16'h4000; req_y0 = 16'h3C00; req_z0 = 16'h0000; req_ctrl0 = 4'b0000;
    req_x1 = 16'h5000; req_y1 = 16'h3C00; req_z1 = 16'h0000; req_ctrl1 = 4'b0101;
    req_valid = 2'b11; n = 0; cnt = 0;
    while (n < 6 && cnt < 80) begin
      mid();
      h = req_valid & req_ready;
      if (h != 2'b00) begin g[n] = h[1]; n++; end
      cyc();
      if (h[0]) req_x0 = req_x0 + 16'h0100;
      if (h[1]) req_x1 = req_x1 + 16'h0100;
      if (n == 6) req_valid = 2'b00;
      cnt++;
    end
    req_valid = 2'b00;
    check("t2_grant_count", n, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t2_grant%0d", i), g[i], i % 2);
    wait_drain("t2_drain");

    // 3: consumer stalled, requester 0 always valid: credit caps at DEPTH
    req_x0 = 16'h4800; req_y0 = 16'h3C00; req_z0 = 16'h0000;
    resp_ready = 1'b0; req_valid = 2'b01; n = 0;
    for (int i = 0; i < 10; i++) begin
      mid();
      h = req_valid & req_ready;
      if (h[0]) n++;
      cyc();
      if (h[0]) req_x0 = req_x0 + 16'h0040;
    end
    mid();
    check("t3_hs_count", n, 4);
    check("t3_ready_blocked", req_ready, 2'b00);
    check("t3_busy", busy, 1);
    check("t3_rvalid", resp_valid, 1);
    cyc(); resp_ready = 1'b1;
    mid(); check("t3_pop_cycle_ready", req_ready, 2'b00);
    cyc(); resp_ready = 1'b0;
    mid(); check("t3_regrant", req_ready, 2'b01);
    cyc(); req_x0 = req_x0 + 16'h0040;
    mid(); check("t3_full_again", req_ready, 2'b00);

    // 4: drain while requesting: simultaneous pop+handshake, FIFO wraps over 10 ops
    cyc(); resp_ready = 1'b1; n = 0; cnt = 0; overlap = 0;
    while (n < 10 && cnt < 100) begin
      mid();
      h = req_valid & req_ready;
      if (h[0] && resp_valid && resp_ready) overlap = 1;
      if (h[0]) n++;
      cyc();
      if (h[0]) req_x0 = req_x0 + 16'h0040;
      if (n == 10) req_valid = 2'b00;
      cnt++;
    end
    req_valid = 2'b00;
    check("t4_ops", n, 10);
    check("t4_overlap", overlap, 1);
    wait_drain("t4_drain");

    // 5: reset with two ops in flight
    req_x0 = 16'h3C00; req_y0 = 16'h3C00; req_z0 = 16'h0000; req_valid = 2'b01;
    mid(); check("t5_hs0", req_ready, 2'b01);
    cyc(); req_x0 = 16'h4400;
    mid(); check("t5_hs1", req_ready, 2'b01);
    cyc(); req_valid = 2'b00; reset_n = 1'b0;
    mid();
    cyc(); reset_n = 1'b1;
    mid();
    check("t5_issue", fma_issue, 0);
    check("t5_fx", fma_x, 0);
    check("t5_fy", fma_y, 0);
    check("t5_fz", fma_z, 0);
    check("t5_fctrl", fma_ctrl, 0);
    check("t5_rvalid", resp_valid, 0);
    check("t5_rdata", resp_data, 0);
    check("t5_rflags", resp_flags, 0);
    check("t5_rid", resp_id, 0);
    check("t5_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); mid();
      if (resp_valid) seen = 1;
    end
    check("t5_no_stale", seen, 0);
    cyc();
    req_x0 = 16'h3C00; req_y0 = 16'h4000; req_z0 = 16'h3C00; req_ctrl0 = 4'b0000;
    req_x1 = 16'h4800; req_y1 = 16'h3C00; req_z1 = 16'h0000; req_ctrl1 = 4'b0000;
    req_valid = 2'b11;
    mid(); check("t5_rr_reset", req_ready, 2'b01);
    cyc(); req_valid = 2'b10;
    mid(); check("t5_req1", req_ready, 2'b10);
    cyc(); req_valid = 2'b00;
    n = 0;
    mid();
    while (!resp_valid && n < 20) begin
      cyc(); mid();
      n++;
    end
    check("t5_after_rdata", resp_data, 16'h4200);
    check("t5_after_rid", resp_id, 0);
    check("t5_after_rflags", resp_flags, 0);
    cyc();
    wait_drain("t5_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
